ahb_lite_reg_bridge: RTL and testbench



---
 rtl/ahb_bridge_pkg.sv | 23 ++
 rtl/ahb_bridge_timeout.sv | 37 +++
 rtl/ahb_lite_reg_bridge.sv | 133 +++++++++++++
 tb/tb_ahb_lite_reg_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-Lite encodings and the bridge state type for the UART register bridge.
// Both the bridge RTL and its bench import this package.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_bridge_timeout.sv
// Wait-state counter: counts register-side stall cycles and flags the last
// allowed one so the bridge can abandon the access.
module ahb_bridge_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

  // Holds at the expiry value so a stray extra tick can never wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_lite_reg_bridge.sv
// AHB-Lite slave that turns each accepted beat into one register read/write
// strobe, with register-side wait states, a stall timeout and two-cycle ERROR.
module ahb_lite_reg_bridge
  import ahb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [REG_AW-1:0]     reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ready,
  output logic [2:0]            dbg_state_o
);

  state_e            state_q, state_d, tgt_state;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic              accept, legal, take;
  logic              wait_tick, wait_expire;

  assign accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign legal  = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00) &&
                  (HADDR[ADDR_WIDTH-1:REG_AW] == '0);

  assign tgt_state   = !legal ? ST_ERR1 : (HWRITE ? ST_WR : ST_RD);
  assign wait_tick   = ((state_q == ST_WR) || (state_q == ST_RD)) && !reg_ready;
  assign dbg_state_o = state_q;

  // A new beat is taken from IDLE, from ERR2, or on the completing cycle of WR/RD.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take = accept;
      end
      ST_WR, ST_RD: begin
        if (reg_ready) begin
          take    = accept;
          state_d = ST_IDLE;
        end else if (wait_expire) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        take    = accept;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (take) begin
      state_d = tgt_state;
      addr_d  = HADDR[REG_AW-1:0];
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    case (state_q)
      ST_WR: begin
        reg_wr_en = 1'b1;
        reg_addr  = addr_q;
        reg_wdata = HWDATA;
        HREADYOUT = reg_ready;
      end
      ST_RD: begin
        reg_rd_en = 1'b1;
        reg_addr  = addr_q;
        HREADYOUT = reg_ready;
        HRDATA    = reg_ready ? reg_rdata : '0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        HRESP = HRESP_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  ahb_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .clear_i  (take),
    .tick_i   (wait_tick),
    .expire_o (wait_expire)
  );

endmodule

// File: tb/tb_ahb_lite_reg_bridge.sv
// Bench for ahb_lite_reg_bridge: single-master AHB driver, register-file
// responder with chosen wait states, and scoreboards for bus and register side.
module tb_ahb_lite_reg_bridge;
  import ahb_bridge_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [7:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wdata;
  logic        reg_rd_en;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic [2:0]  dbg_state;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Only slave on the bus: global HREADY is this slave's HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb_lite_reg_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .REG_AW     (8),
    .TIMEOUT    (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wdata   (reg_wdata),
    .reg_rd_en   (reg_rd_en),
    .reg_rdata   (reg_rdata),
    .reg_ready   (reg_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking core ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
  } xfer_t;

  typedef struct {
    logic        abandon;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          run;
  } racc_t;

  xfer_t       stim_q[$];
  logic [32:0] exp_q[$];   // {hresp, hrdata} per accepted beat
  racc_t       reg_q[$];   // expected register-side accesses
  int          wait_q[$];  // responder wait states per register access

  logic [31:0] model_mem [64];
  logic        d_active;
  logic        mon_en;
  logic        resp_en;

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                               input int waits);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.addr = addr; t.wr = wr;
    t.size = size; t.wdata = wdata; t.waits = waits;
    return t;
  endfunction

  // Reference model: decides the outcome of an accepted beat from the access rules.
  task automatic issue(input xfer_t t);
    racc_t r;
    logic  legal;
    legal = (t.size == HSIZE_WORD) && (t.addr % 4 == 0) && (t.addr < 256);
    if (!legal) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      wait_q.push_back(t.waits);
      r.wr = t.wr; r.addr = t.addr[7:0]; r.wdata = t.wdata;
      if (t.waits >= TO) begin
        r.abandon = 1'b1; r.run = TO;
        exp_q.push_back({1'b1, 32'h0});
      end else begin
        r.abandon = 1'b0; r.run = t.waits + 1;
        if (t.wr) begin
          model_mem[t.addr / 4] = t.wdata;
          exp_q.push_back({1'b0, 32'h0});
        end else begin
          exp_q.push_back({1'b0, model_mem[t.addr / 4]});
        end
      end
      reg_q.push_back(r);
    end
  endtask

  task automatic drive_addr(input xfer_t t);
    HSEL = t.sel; HTRANS = t.trans; HADDR = t.addr; HWRITE = t.wr; HSIZE = t.size;
  endtask

  // ---------------- register-file responder ----------------
  logic [31:0] rsp_mem [64];
  logic        s_stb, s_rdy, s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic        in_acc;
  int          wait_left;

  always @(negedge HCLK) begin
    s_stb   = reg_wr_en || reg_rd_en;
    s_rdy   = reg_ready;
    s_wr    = reg_wr_en;
    s_addr  = reg_addr;
    s_wdata = reg_wdata;
  end

  initial begin
    reg_ready = 1'b0;
    reg_rdata = '0;
    in_acc    = 1'b0;
    wait_left = 0;
    forever begin
      @(posedge HCLK);
      #2;
      if (!resp_en || !HRESETn) begin
        in_acc    = 1'b0;
        reg_ready = 1'b0;
        reg_rdata = $urandom;
      end else begin
        if (in_acc && s_stb && s_rdy) begin
          in_acc = 1'b0;
          if (s_wr) rsp_mem[s_addr >> 2] = s_wdata;
        end else if (in_acc && s_stb) begin
          wait_left--;
        end
        if (!(reg_wr_en || reg_rd_en)) begin
          in_acc = 1'b0;
        end else if (!in_acc) begin
          in_acc    = 1'b1;
          wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        reg_ready = in_acc ? (wait_left == 0) : 1'($urandom_range(0, 1));
        reg_rdata = (in_acc && reg_rd_en && wait_left == 0) ? rsp_mem[reg_addr >> 2] : $urandom;
      end
    end
  end

  // ---------------- bus-side monitor ----------------
  logic        prev_rdy, prev_resp;
  logic [32:0] bus_exp;

  always @(negedge HCLK) begin
    if (mon_en && HRESETn) begin
      if (d_active) begin
        if (HREADYOUT) begin
          if (exp_q.size() == 0) begin
            chk("resp_queue_nonempty", exp_q.size(), 1);
          end else begin
            bus_exp = exp_q.pop_front();
            chk("hresp", HRESP, bus_exp[32]);
            chk("hrdata", HRDATA, bus_exp[31:0]);
            if (bus_exp[32]) chk("err_first_cycle", {prev_rdy, prev_resp}, 2'b01);
          end
        end
      end else begin
        chk("idle_okay", {HREADYOUT, HRESP}, 2'b10);
      end
      prev_rdy  = HREADYOUT;
      prev_resp = HRESP;
    end
  end

  // ---------------- register-side monitor ----------------
  racc_t rexp;
  int    run = 0;
  logic  bad = 1'b0;
  logic  obs_abandon;

  always @(negedge HCLK) begin
    if (mon_en && HRESETn) begin
      if (reg_wr_en || reg_rd_en) begin
        if (reg_q.size() == 0) begin
          chk("strobe_without_access", {reg_wr_en, reg_rd_en}, 2'b00);
        end else begin
          rexp = reg_q[0];
          run++;
          if ({reg_wr_en, reg_rd_en} != (rexp.wr ? 2'b10 : 2'b01) || reg_addr != rexp.addr ||
              (rexp.wr && reg_wdata != rexp.wdata)) bad = 1'b1;
          if (reg_ready) begin
            obs_abandon = 1'b0;
            void'(reg_q.pop_front());
            chk("reg_end_kind", obs_abandon, rexp.abandon);
            chk("reg_strobe_cycles", run, rexp.run);
            chk("reg_fields_stable", bad, 1'b0);
            run = 0; bad = 1'b0;
          end
        end
      end else if (run > 0) begin
        obs_abandon = 1'b1;
        rexp = reg_q.pop_front();
        chk("reg_end_kind", obs_abandon, rexp.abandon);
        chk("reg_strobe_cycles", run, rexp.run);
        chk("reg_fields_stable", bad, 1'b0);
        run = 0; bad = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  xfer_t a_cur;
  xfer_t idle_x;
  logic  hr;
  int    cyc;
  int    r, w;
  xfer_t t;

  initial begin
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 32'hC0DE_0000 + i;
      rsp_mem[i]   = {16'hC0DE, 10'd0, 6'(i)};
    end
    idle_x   = mk(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 0);
    HRESETn  = 1'b0;
    d_active = 1'b0;
    mon_en   = 1'b0;
    resp_en  = 1'b0;
    HWDATA   = '0;
    drive_addr(idle_x);

    // Reset values.
    repeat (2) @(negedge HCLK);
    chk("rst_hreadyout", HREADYOUT, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_wr_en", reg_wr_en, 1'b0);
    chk("rst_rd_en", reg_rd_en, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    HRESETn = 1'b1;

    // Reset asserted in the middle of a stalled write.
    @(posedge HCLK); #1;
    drive_addr(mk(1'b1, HTRANS_NONSEQ, 32'h08, 1'b1, HSIZE_WORD, 32'h0, 0));
    @(posedge HCLK); #1;
    drive_addr(idle_x);
    HWDATA = 32'h1111_2222;
    @(negedge HCLK);
    chk("mid_wr_en", reg_wr_en, 1'b1);
    chk("mid_addr", reg_addr, 8'h08);
    chk("mid_wdata", reg_wdata, 32'h1111_2222);
    chk("mid_hreadyout", HREADYOUT, 1'b0);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_wr_drop", reg_wr_en, 1'b0);
    chk("async_hreadyout", HREADYOUT, 1'b1);
    chk("async_hresp", HRESP, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      chk("post_rst_no_strobe", {reg_wr_en, reg_rd_en}, 2'b00);
      chk("post_rst_ready", {HREADYOUT, HRESP}, 2'b10);
    end

    // Directed beats: zero-wait, wait states, illegal accesses, timeout boundaries, bursts.
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h08, 1, HSIZE_WORD, 32'hA5A5_0001, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h08, 0, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h04, 0, HSIZE_WORD, 32'h0, 3));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h0C, 1, 3'b000, 32'hDEAD_0001, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h02, 0, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h100, 1, HSIZE_WORD, 32'hDEAD_0002, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD, 32'hDEAD_0003, 20));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD, 32'h0, TO - 1));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h14, 1, HSIZE_WORD, 32'hDEAD_0004, TO));
    stim_q.push_back(mk(1, HTRANS_IDLE, 32'h18, 1, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(1, HTRANS_BUSY, 32'h18, 1, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(0, HTRANS_NONSEQ, 32'h18, 1, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h00, 1, HSIZE_WORD, 32'hB000_0000, 0));
    stim_q.push_back(mk(1, HTRANS_SEQ, 32'h04, 1, HSIZE_WORD, 32'hB000_0004, 0));
    stim_q.push_back(mk(1, HTRANS_SEQ, 32'h08, 1, HSIZE_WORD, 32'hB000_0008, 0));
    stim_q.push_back(mk(1, HTRANS_SEQ, 32'h0C, 1, HSIZE_WORD, 32'hB000_000C, 0));
    stim_q.push_back(mk(1, HTRANS_NONSEQ, 32'h00, 0, HSIZE_WORD, 32'h0, 0));
    stim_q.push_back(mk(1, HTRANS_SEQ, 32'h0C, 0, HSIZE_WORD, 32'h0, 0));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      w = (r == 0) ? $urandom_range(TO - 1, TO + 4) : (r < 12) ? 0 : $urandom_range(1, 4);
      t = mk(1'b1, $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ,
             32'(4 * $urandom_range(0, 63)), 1'($urandom_range(0, 1)), HSIZE_WORD, $urandom, w);
      r = $urandom_range(0, 99);
      if (r < 6) t.trans = HTRANS_IDLE;
      else if (r < 10) t.trans = HTRANS_BUSY;
      else if (r < 14) t.sel = 1'b0;
      else if (r < 18) t.size = 3'($urandom_range(0, 1));
      else if (r < 22) t.addr = t.addr + 32'($urandom_range(1, 3));
      else if (r < 26) t.addr = 32'((1 + $urandom_range(0, 1000)) * 256) + t.addr;
      stim_q.push_back(t);
    end

    resp_en = 1'b1;
    mon_en  = 1'b1;
    a_cur   = idle_x;
    drive_addr(a_cur);
    cyc = 0;
    while ((stim_q.size() > 0 || d_active || (a_cur.sel && a_cur.trans[1])) && cyc < 20000) begin
      @(negedge HCLK);
      hr = HREADYOUT;
      @(posedge HCLK);
      #1;
      cyc++;
      if (hr) begin
        if (a_cur.sel && a_cur.trans[1]) begin
          d_active = 1'b1;
          HWDATA   = a_cur.wr ? a_cur.wdata : $urandom;
          issue(a_cur);
        end else begin
          d_active = 1'b0;
          HWDATA   = $urandom;
        end
        a_cur = (stim_q.size() > 0) ? stim_q.pop_front() : idle_x;
        drive_addr(a_cur);
      end
    end
    chk("traffic_within_budget", (cyc < 20000), 1'b1);

    repeat (5) @(negedge HCLK);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("reg_queue_drained", reg_q.size(), 0);
    chk("wait_queue_drained", wait_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
